// File: rtl/huffman_symbol_sequencer.sv
// Turns one latched block of zigzag coefficients into DC/AC/ZRL/EOB run-size symbols.
// DC symbol appears the cycle after start, then one symbol per emit state; sym_* hold while sym_ready is low.
module huffman_symbol_sequencer #(
  parameter int PIX_W = 10,
  parameter int NPIX  = 64,
  parameter int NCOMP = 3,
  parameter int CW    = (NCOMP > 1) ? $clog2(NCOMP) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [CW-1:0]           comp_id,
  input  logic [NPIX*PIX_W-1:0]   coef_in,
  input  logic                    dc_clear,
  output logic                    busy,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic                    sym_is_dc,
  output logic [3:0]              sym_run,
  output logic [3:0]              sym_size,
  output logic [PIX_W:0]          sym_amp,
  output logic                    sym_eob,
  output logic [CW-1:0]           sym_comp,
  output logic                    blk_done
);

  localparam int AW = PIX_W + 1;
  localparam int IW = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int RW = (IW + 1 > 5) ? IW + 1 : 5;

  typedef enum logic [2:0] {IDLE, DC, SCAN, EMIT, EOB, DONE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [RW-1:0]     run_q, run_d;
  logic [CW-1:0]     comp_q;
  logic [PIX_W-1:0]  coef_q [NPIX];
  logic [PIX_W-1:0]  pred_q [NCOMP];
  logic              clr_pend_q;

  logic              latch_en;
  logic              dc_wb;
  logic              clr_now;
  logic [AW-1:0]     dc_val;
  logic [PIX_W-1:0]  cur_coef;
  logic [AW-1:0]     ac_val;
  logic              last_idx;

  function automatic logic [3:0] mag_size(input logic [AW-1:0] v);
    logic [AW-1:0] mag;
    logic [3:0]    s;
    mag = v[AW-1] ? (~v + 1'b1) : v;
    s   = 4'd0;
    for (int i = 0; i < AW; i++) begin
      if (mag[i]) s = 4'(i + 1);
    end
    return s;
  endfunction

  // Negative values are sent as (value-1) truncated to size bits.
  function automatic logic [AW-1:0] amp_bits(input logic [AW-1:0] v, input logic [3:0] sz);
    logic [AW-1:0] t;
    t = v[AW-1] ? (v - 1'b1) : v;
    for (int i = 0; i < AW; i++) begin
      if (i >= int'(sz)) t[i] = 1'b0;
    end
    return t;
  endfunction

  assign dc_val   = {coef_q[0][PIX_W-1], coef_q[0]} - {pred_q[comp_q][PIX_W-1], pred_q[comp_q]};
  assign cur_coef = coef_q[idx_q];
  assign ac_val   = {cur_coef[PIX_W-1], cur_coef};
  assign last_idx = (idx_q == IW'(NPIX - 1));
  assign sym_comp = comp_q;
  // A clear seen mid-block waits until the block's predictor writeback is done.
  assign clr_now  = (dc_clear || clr_pend_q) && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    run_d     = run_q;
    latch_en  = 1'b0;
    dc_wb     = 1'b0;
    busy      = 1'b0;
    sym_valid = 1'b0;
    sym_is_dc = 1'b0;
    sym_run   = 4'd0;
    sym_size  = 4'd0;
    sym_amp   = '0;
    sym_eob   = 1'b0;
    blk_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch_en = 1'b1;
          state_d  = DC;
        end
      end
      DC: begin
        busy      = 1'b1;
        sym_valid = 1'b1;
        sym_is_dc = 1'b1;
        sym_size  = mag_size(dc_val);
        sym_amp   = amp_bits(dc_val, mag_size(dc_val));
        if (sym_ready) begin
          dc_wb   = 1'b1;
          state_d = SCAN;
          idx_d   = IW'(1);
          run_d   = '0;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if (cur_coef == '0) begin
          run_d = run_q + 1'b1;
          if (last_idx) state_d = EOB;
          else          idx_d   = idx_q + 1'b1;
        end else begin
          state_d = EMIT;
        end
      end
      EMIT: begin
        busy      = 1'b1;
        sym_valid = 1'b1;
        if (run_q >= RW'(16)) begin
          sym_run = 4'd15;
          if (sym_ready) run_d = run_q - RW'(16);
        end else begin
          sym_run  = run_q[3:0];
          sym_size = mag_size(ac_val);
          sym_amp  = amp_bits(ac_val, mag_size(ac_val));
          if (sym_ready) begin
            run_d = '0;
            if (last_idx) begin
              state_d = DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = SCAN;
            end
          end
        end
      end
      EOB: begin
        busy      = 1'b1;
        sym_valid = 1'b1;
        sym_eob   = 1'b1;
        if (sym_ready) state_d = DONE;
      end
      DONE: begin
        blk_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      run_q      <= '0;
      comp_q     <= '0;
      clr_pend_q <= 1'b0;
      for (int k = 0; k < NPIX; k++) coef_q[k] <= '0;
      for (int c = 0; c < NCOMP; c++) pred_q[c] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      if (latch_en) begin
        for (int k = 0; k < NPIX; k++) coef_q[k] <= coef_in[k*PIX_W +: PIX_W];
        comp_q <= ({1'b0, comp_id} < (CW+1)'(NCOMP)) ? comp_id : '0;
      end
      if (dc_wb) pred_q[comp_q] <= coef_q[0];
      if (clr_now) begin
        for (int c = 0; c < NCOMP; c++) pred_q[c] <= '0;
        clr_pend_q <= 1'b0;
      end else if (dc_clear) begin
        clr_pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_huffman_symbol_sequencer.sv
// Directed bench for huffman_symbol_sequencer: hand-computed DC/AC/ZRL/EOB sequences.
module tb_huffman_symbol_sequencer;
  localparam int PIX_W = 10;
  localparam int NPIX  = 64;
  localparam int NCOMP = 3;
  localparam int CW    = 2;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  start;
  logic [CW-1:0]         comp_id;
  logic [NPIX*PIX_W-1:0] coef_in;
  logic                  dc_clear;
  logic                  busy;
  logic                  sym_valid;
  logic                  sym_ready;
  logic                  sym_is_dc;
  logic [3:0]            sym_run;
  logic [3:0]            sym_size;
  logic [PIX_W:0]        sym_amp;
  logic                  sym_eob;
  logic [CW-1:0]         sym_comp;
  logic                  blk_done;

  int errors = 0;
  int checks = 0;
  int xfer_cnt = 0;
  int exp_comp = 0;
  int base;

  huffman_symbol_sequencer #(.PIX_W(PIX_W), .NPIX(NPIX), .NCOMP(NCOMP), .CW(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .comp_id(comp_id), .coef_in(coef_in),
    .dc_clear(dc_clear), .busy(busy), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .sym_is_dc(sym_is_dc), .sym_run(sym_run), .sym_size(sym_size), .sym_amp(sym_amp),
    .sym_eob(sym_eob), .sym_comp(sym_comp), .blk_done(blk_done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!reset && sym_valid && sym_ready) xfer_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_coef(input int k, input int v);
    logic [31:0] w;
    w = v;
    coef_in[k*PIX_W +: PIX_W] = w[PIX_W-1:0];
  endtask

  task automatic start_blk(input int comp, input logic clr);
    comp_id  = CW'(comp);
    start    = 1'b1;
    dc_clear = clr;
    @(negedge clock);
    start    = 1'b0;
    dc_clear = 1'b0;
    check_val("busy_rise", busy, 1);
  endtask

  task automatic expect_sym(input string tag, input int dc, input int run, input int size,
                            input int amp, input int eob);
    int n;
    n = 0;
    while (!sym_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_val({tag, "_vld"},  sym_valid, 1);
    check_val({tag, "_dc"},   sym_is_dc, dc);
    check_val({tag, "_run"},  sym_run, run);
    check_val({tag, "_size"}, sym_size, size);
    check_val({tag, "_amp"},  sym_amp, amp);
    check_val({tag, "_eob"},  sym_eob, eob);
    check_val({tag, "_comp"}, sym_comp, exp_comp);
    @(negedge clock);
  endtask

  task automatic expect_done(input string tag);
    int n;
    n = 0;
    while (!blk_done && !sym_valid && n < 200) begin
      @(negedge clock);
      n++;
    end
    check_val({tag, "_done"},    blk_done, 1);
    check_val({tag, "_nosym"},   sym_valid, 0);
    check_val({tag, "_busylow"}, busy, 0);
    @(negedge clock);
    check_val({tag, "_pulse"},   blk_done, 0);
    check_val({tag, "_idle"},    busy, 0);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    comp_id   = '0;
    coef_in   = '0;
    dc_clear  = 1'b0;
    sym_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check_val("rst_busy", busy, 0);
    check_val("rst_vld", sym_valid, 0);
    check_val("rst_done", blk_done, 0);
    check_val("rst_comp", sym_comp, 0);

    // DC only, then predictor reuse
    exp_comp = 0; coef_in = '0; set_coef(0, 5);
    start_blk(0, 1'b0);
    expect_sym("t1_dc", 1, 0, 3, 5, 0);
    expect_sym("t1_eob", 0, 0, 0, 0, 1);
    expect_done("t1");

    coef_in = '0; set_coef(0, 2);
    start_blk(0, 1'b0);
    expect_sym("t2_dc", 1, 0, 2, 0, 0);
    expect_sym("t2_eob", 0, 0, 0, 0, 1);
    expect_done("t2");

    // ZRL then AC(-1)
    exp_comp = 1; coef_in = '0; set_coef(20, -1);
    start_blk(1, 1'b0);
    expect_sym("t3_dc", 1, 0, 0, 0, 0);
    expect_sym("t3_zrl", 0, 15, 0, 0, 0);
    expect_sym("t3_ac", 0, 3, 1, 0, 0);
    expect_sym("t3_eob", 0, 0, 0, 0, 1);
    expect_done("t3");

    // last coefficient nonzero: three ZRLs, no EOB
    exp_comp = 2; coef_in = '0; set_coef(63, 7);
    start_blk(2, 1'b0);
    expect_sym("t4_dc", 1, 0, 0, 0, 0);
    expect_sym("t4_zrl0", 0, 15, 0, 0, 0);
    expect_sym("t4_zrl1", 0, 15, 0, 0, 0);
    expect_sym("t4_zrl2", 0, 15, 0, 0, 0);
    expect_sym("t4_ac", 0, 14, 3, 7, 0);
    expect_done("t4");

    // backpressure on the AC symbol, start and coef_in changes ignored while busy
    exp_comp = 1; coef_in = '0; set_coef(2, 3);
    base = xfer_cnt;
    start_blk(1, 1'b0);
    expect_sym("t5_dc", 1, 0, 0, 0, 0);
    sym_ready = 1'b0;
    for (int n = 0; n < 20 && !sym_valid; n++) @(negedge clock);
    for (int c = 0; c < 5; c++) begin
      if (c == 0) begin
        start = 1'b1; comp_id = 2'd2;
        for (int k = 0; k < NPIX; k++) set_coef(k, 85);
      end else begin
        start = 1'b0;
      end
      check_val("t5_hold_vld", sym_valid, 1);
      check_val("t5_hold_run", sym_run, 1);
      check_val("t5_hold_size", sym_size, 2);
      check_val("t5_hold_amp", sym_amp, 3);
      @(negedge clock);
    end
    start = 1'b0;
    sym_ready = 1'b1;
    expect_sym("t5_ac", 0, 1, 2, 3, 0);
    expect_sym("t5_eob", 0, 0, 0, 0, 1);
    expect_done("t5");
    check_val("t5_xfers", xfer_cnt - base, 3);

    // reset mid-scan clears predictors
    exp_comp = 0; coef_in = '0; set_coef(0, 9);
    start_blk(0, 1'b0);
    expect_sym("t6_dc", 1, 0, 3, 7, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_val("t6_rst_busy", busy, 0);
    check_val("t6_rst_vld", sym_valid, 0);
    check_val("t6_rst_done", blk_done, 0);
    coef_in = '0; set_coef(0, 4);
    start_blk(0, 1'b0);
    expect_sym("t6b_dc", 1, 0, 3, 4, 0);
    expect_sym("t6b_eob", 0, 0, 0, 0, 1);
    expect_done("t6b");

    // dc_clear during DC: writeback first, clear at block end
    coef_in = '0; set_coef(0, 6);
    sym_ready = 1'b0;
    start_blk(0, 1'b0);
    dc_clear = 1'b1;
    @(negedge clock);
    dc_clear = 1'b0;
    sym_ready = 1'b1;
    expect_sym("t7_dc", 1, 0, 2, 2, 0);
    expect_sym("t7_eob", 0, 0, 0, 0, 1);
    expect_done("t7");
    coef_in = '0; set_coef(0, 1);
    start_blk(3, 1'b0);
    expect_sym("t7b_dc", 1, 0, 1, 1, 0);
    expect_sym("t7b_eob", 0, 0, 0, 0, 1);
    expect_done("t7b");

    // negative DC, then dc_clear together with start
    exp_comp = 2; coef_in = '0; set_coef(0, -4);
    start_blk(2, 1'b0);
    expect_sym("t8_dc", 1, 0, 3, 3, 0);
    expect_sym("t8_eob", 0, 0, 0, 0, 1);
    expect_done("t8");
    coef_in = '0; set_coef(0, 5);
    start_blk(2, 1'b1);
    expect_sym("t8b_dc", 1, 0, 3, 5, 0);
    expect_sym("t8b_eob", 0, 0, 0, 0, 1);
    expect_done("t8b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/huffman_symbol_sequencer.md
HUFFMAN_SYMBOL_SEQUENCER -- requirements
Module: huffman_symbol_sequencer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  PIX_W  10  signed coefficient width, legal range 2..14
  NPIX  64  coefficients per block, zigzag order
  NCOMP  3  component channels, each with its own DC predictor
  CW  $clog2(NCOMP) (min 1)  component-id width
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clock  in  1  single clock, rising edge
  reset  in  1  synchronous, active-high
  start  in  1  request to encode one block
  comp_id  in  CW  component of the block, sampled with start
  coef_in  in  NPIX*PIX_W  zigzag coefficients; coef k in bits [k*PIX_W +: PIX_W]
  dc_clear  in  1  zero all DC predictors (restart marker)
  busy  out  1  block in progress
  sym_valid  out  1  symbol present
  sym_ready  in  1  downstream accepts symbol
  sym_is_dc  out  1  symbol is the DC difference
  sym_run  out  4  zero run preceding the AC coefficient
  sym_size  out  4  magnitude category
  sym_amp  out  PIX_W+1  amplitude bits, LSB-aligned, upper bits 0
  sym_eob  out  1  end-of-block symbol
  sym_comp  out  CW  component of the current block
  blk_done  out  1  one-cycle pulse when the block is finished

Function
REQ-003 The FSM SHALL have states IDLE, DC, SCAN, EMIT, EOB and DONE.
REQ-004 In IDLE, start=1 SHALL latch coef_in and comp_id; busy rises the next cycle; start outside IDLE SHALL be ignored.
REQ-005 DC: diff = coef0 - pred[comp], computed at PIX_W+1 bits signed; sym_valid=1, sym_is_dc=1, sym_run=0, in the first cycle after start.
REQ-006 sym_size = number of significant bits of |value| (0 for value 0).
REQ-007 sym_amp = value if value>0, else (value-1) masked to sym_size bits (ones'-complement form).
REQ-008 A symbol SHALL be transferred only on a cycle with sym_valid & sym_ready.
REQ-009 While sym_valid=1 and sym_ready=0, all sym_* outputs SHALL hold stable.
REQ-010 On the DC transfer: pred[comp] <= coef0, then go to SCAN with index=1, run=0.
REQ-011 SCAN SHALL examine one coefficient per cycle and emit no symbol for a zero coefficient: run += 1, index += 1.
REQ-012 Nonzero coefficient with run>=16: go to EMIT with a ZRL symbol (run=15, size=0, amp=0), then run -= 16; repeat until run<16.
REQ-013 Nonzero coefficient with run<16: go to EMIT with an AC symbol (run, size, amp), then run=0, index += 1.
REQ-014 After index NPIX-1 is processed, if run>0 go to EOB: emit run=0, size=0, sym_eob=1.
REQ-015 If the last coefficient is nonzero, no EOB SHALL be emitted, and no trailing ZRL SHALL ever be emitted.
REQ-016 DONE SHALL pulse blk_done for one cycle, drop busy in that same cycle, and return to IDLE; start is accepted again the following cycle.
REQ-017 dc_clear SHALL zero all predictors at the clock edge.
REQ-018 dc_clear and start in the same cycle: the clear applies first, so the DC diff equals coef0.
REQ-019 dc_clear while busy SHALL take effect after the current block: pred writeback first, then clear; the clear is held pending until DONE.
REQ-020 sym_comp SHALL equal the latched comp_id for every symbol of the block.
REQ-021 The latched coefficients SHALL be unaffected by coef_in changes during busy.
REQ-022 A comp_id >= NCOMP SHALL be treated as 0.

Reset
REQ-023 reset=1 SHALL force IDLE in every state, including mid-block with a symbol pending.
REQ-024 reset SHALL set all outputs to 0, clear all predictors, clear the pending dc_clear, and discard the latched block.

Verification
REQ-025 Bench SHALL cover:
  - comp 0, pred 0, coef0=5, AC all zero, ready=1 -> DC(size3, amp5), EOB, blk_done; pred0=5.
  - Next block comp 0, coef0=2 -> DC diff -3: size2, amp2'b00.
  - coef[20]=-1, others 0, coef0=0 -> DC(size0), ZRL, AC(run3, size1, amp0), EOB.
  - coef[63]=7 only -> DC, 3x ZRL, AC(run14, size3, amp7), no EOB.
  - ready low 5 cycles on the AC symbol -> outputs stable; exactly one transfer.
  - reset mid-SCAN -> busy=0, sym_valid=0 next cycle; the next block's DC diff equals coef0.
